// File: rtl/npu_op_sequencer_if.sv
// Command and im2col local-control signals between the op sequencer and its environment.
// The master modport is the sequencer's view; slave is the register front end / im2col side.
interface npu_op_sequencer_if #(
    parameter int SLICE_W = 16
);
    logic               i_cmd_valid;
    logic               o_cmd_ready;
    logic [1:0]         i_cmd_mode;
    logic [SLICE_W-1:0] i_cmd_slices;
    logic               i_abort;
    logic [1:0]         o_op_mode;
    logic [SLICE_W-1:0] o_slice_number;
    logic               o_set_param;
    logic               o_start_mac;
    logic               o_start_pool;
    logic               o_terminate;
    logic               i_image_ready;
    logic               i_done;
    logic               i_pool_done;
    logic               o_busy;
    logic [SLICE_W-1:0] o_slice_count;
    logic               o_op_done;
    logic               o_error;

    modport master (
        input  i_cmd_valid, i_cmd_mode, i_cmd_slices, i_abort,
        input  i_image_ready, i_done, i_pool_done,
        output o_cmd_ready, o_op_mode, o_slice_number,
        output o_set_param, o_start_mac, o_start_pool, o_terminate,
        output o_busy, o_slice_count, o_op_done, o_error
    );

    modport slave (
        output i_cmd_valid, i_cmd_mode, i_cmd_slices, i_abort,
        output i_image_ready, i_done, i_pool_done,
        input  o_cmd_ready, o_op_mode, o_slice_number,
        input  o_set_param, o_start_mac, o_start_pool, o_terminate,
        input  o_busy, o_slice_count, o_op_done, o_error
    );
endinterface

// File: rtl/npu_op_sequencer.sv
// Runs one im2col command (set_param / start_mac|start_pool / terminate handshake); all outputs registered, requests one cycle after accept.
// Single command in flight: o_cmd_ready low until the terminate handshake completes; requests are held until acked.
module npu_op_sequencer #(
    parameter int SLICE_W     = 16,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic               i_clk,
    input  logic               i_reset,
    npu_op_sequencer_if.master bus
);
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = (WDOG_CYCLES > 0) ? WDOG_W'(WDOG_CYCLES - 1) : '0;
    localparam logic [1:0] MODE_NOP  = 2'b00;
    localparam logic [1:0] MODE_POOL = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE, S_SETP, S_START_MAC, S_WAIT_DONE, S_NEXT, S_START_POOL, S_WAIT_POOL, S_TERM
    } state_t;

    state_t             state_q;
    logic               cmd_ready_q, set_param_q, start_mac_q, start_pool_q, terminate_q;
    logic               busy_q, op_done_q, error_q, aborted_q;
    logic [1:0]         op_mode_q;
    logic [SLICE_W-1:0] slice_number_q, slice_count_q, slice_count_d;
    logic [WDOG_W-1:0]  wdog_q;
    logic               wdog_hit, abort_req, cmd_reject;

    always_comb begin
        slice_count_d = (&slice_count_q) ? slice_count_q : slice_count_q + 1'b1;
        wdog_hit      = (WDOG_CYCLES != 0) && (wdog_q == WDOG_LAST);
        abort_req     = bus.i_abort || wdog_hit;
        cmd_reject    = (bus.i_cmd_mode == MODE_NOP) ||
                        ((bus.i_cmd_mode != MODE_POOL) && (bus.i_cmd_slices == '0));
    end

    // wdog_q counts cycles spent in the current state; every transition below clears it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= S_IDLE;
            cmd_ready_q    <= 1'b1;
            set_param_q    <= 1'b0;
            start_mac_q    <= 1'b0;
            start_pool_q   <= 1'b0;
            terminate_q    <= 1'b0;
            busy_q         <= 1'b0;
            op_done_q      <= 1'b0;
            error_q        <= 1'b0;
            aborted_q      <= 1'b0;
            op_mode_q      <= '0;
            slice_number_q <= '0;
            slice_count_q  <= '0;
            wdog_q         <= '0;
        end else begin
            op_done_q <= 1'b0;
            error_q   <= 1'b0;
            wdog_q    <= wdog_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    wdog_q <= '0;
                    if (bus.i_cmd_valid && cmd_ready_q) begin
                        if (cmd_reject) begin
                            error_q <= 1'b1;
                        end else begin
                            state_q        <= S_SETP;
                            cmd_ready_q    <= 1'b0;
                            busy_q         <= 1'b1;
                            set_param_q    <= 1'b1;
                            aborted_q      <= 1'b0;
                            op_mode_q      <= bus.i_cmd_mode;
                            slice_number_q <= bus.i_cmd_slices;
                            slice_count_q  <= '0;
                        end
                    end
                end
                S_TERM: begin
                    if (!bus.i_image_ready && !bus.i_done) begin
                        state_q     <= S_IDLE;
                        terminate_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        op_done_q   <= !aborted_q;
                        error_q     <= aborted_q;
                        wdog_q      <= '0;
                    end
                end
                default: begin
                    // Abort (external or watchdog) outranks any handshake progress, including i_done.
                    if (abort_req) begin
                        state_q      <= S_TERM;
                        set_param_q  <= 1'b0;
                        start_mac_q  <= 1'b0;
                        start_pool_q <= 1'b0;
                        terminate_q  <= 1'b1;
                        aborted_q    <= 1'b1;
                        wdog_q       <= '0;
                    end else begin
                        case (state_q)
                            S_SETP: if (bus.i_image_ready) begin
                                set_param_q <= 1'b0;
                                wdog_q      <= '0;
                                if (op_mode_q == MODE_POOL) begin
                                    state_q      <= S_START_POOL;
                                    start_pool_q <= 1'b1;
                                end else begin
                                    state_q     <= S_START_MAC;
                                    start_mac_q <= 1'b1;
                                end
                            end
                            S_START_MAC: if (!bus.i_image_ready) begin
                                state_q     <= S_WAIT_DONE;
                                start_mac_q <= 1'b0;
                                wdog_q      <= '0;
                            end
                            S_WAIT_DONE: if (bus.i_done) begin
                                slice_count_q <= slice_count_d;
                                wdog_q        <= '0;
                                if (slice_count_d == slice_number_q) begin
                                    state_q     <= S_TERM;
                                    terminate_q <= 1'b1;
                                end else begin
                                    state_q <= S_NEXT;
                                end
                            end
                            S_NEXT: if (!bus.i_done && bus.i_image_ready) begin
                                state_q     <= S_START_MAC;
                                start_mac_q <= 1'b1;
                                wdog_q      <= '0;
                            end
                            S_START_POOL: if (!bus.i_image_ready) begin
                                state_q      <= S_WAIT_POOL;
                                start_pool_q <= 1'b0;
                                wdog_q       <= '0;
                            end
                            S_WAIT_POOL: if (bus.i_pool_done) begin
                                state_q     <= S_TERM;
                                terminate_q <= 1'b1;
                                wdog_q      <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.o_cmd_ready    = cmd_ready_q;
    assign bus.o_op_mode      = op_mode_q;
    assign bus.o_slice_number = slice_number_q;
    assign bus.o_set_param    = set_param_q;
    assign bus.o_start_mac    = start_mac_q;
    assign bus.o_start_pool   = start_pool_q;
    assign bus.o_terminate    = terminate_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_slice_count  = slice_count_q;
    assign bus.o_op_done      = op_done_q;
    assign bus.o_error        = error_q;
endmodule
